// File: rtl/parity_checker.sv
// parity_checker: one-entry register slice flagging 17-bit even-parity errors; trips FAULT after ERR_LIMIT consecutive errors.
// Latency: exactly 1 cycle from input transfer to out_valid/out_data/out_err.
// Backpressure: in_ready = RUN & (~out_valid | out_ready); FAULT blocks input while the held word still drains.
// Optional feature: define PARITY_CHECKER_ERRCNT_EN to add the saturating err_count port.

module parity_checker #(
  parameter int unsigned ERR_LIMIT = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_parity,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_err,
  input  logic        clr_fault,
  output logic        fault
`ifdef PARITY_CHECKER_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_count
`endif
);

  // Reject parameter values the counters cannot represent.
  if (ERR_LIMIT < 1 || ERR_LIMIT > 255 || CNT_W < 1) begin : g_illegal_cfg
    $error("parity_checker: ERR_LIMIT must be 1..255 and CNT_W >= 1");
  end

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_e;

  // 9 bits so the compare against a limit of 255 cannot overflow.
  localparam logic [8:0] LIMIT = 9'(ERR_LIMIT);

  state_e      state_q, state_d;
  logic [7:0]  consec_q, consec_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic        out_err_q, out_err_d;

  logic        in_xfer;
  logic        out_xfer;
  logic        word_err;
  logic [8:0]  consec_inc;
  logic        hit_limit;

  // Handshake: ready never looks at in_valid, only at state and downstream.
  assign in_ready   = (state_q == RUN) & (~out_valid_q | out_ready);
  assign in_xfer    = in_valid & in_ready;
  assign out_xfer   = out_valid_q & out_ready;

  // Data bits plus parity must have even weight.
  assign word_err   = (^in_data) ^ in_parity;
  assign consec_inc = {1'b0, consec_q} + 9'd1;
  assign hit_limit  = word_err & (consec_inc >= LIMIT);

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_err    = out_err_q;
  assign fault      = (state_q == FAULT);

  // Next-state logic for RUN/FAULT and the consecutive-error run length.
  always_comb begin
    state_d  = state_q;
    consec_d = consec_q;
    case (state_q)
      RUN: begin
        // A clear in RUN only restarts the run length; it wins over a
        // same-cycle errored word so the clear is never lost.
        if (clr_fault) begin
          consec_d = '0;
        end else if (in_xfer) begin
          if (word_err) begin
            consec_d = consec_inc[7:0];
            if (hit_limit) begin
              state_d = FAULT;
            end
          end else begin
            consec_d = '0;
          end
        end
      end
      FAULT: begin
        if (clr_fault) begin
          state_d  = RUN;
          consec_d = '0;
        end
      end
      default: begin
        state_d  = RUN;
        consec_d = '0;
      end
    endcase
  end

  // Next-state logic for the one-entry output slice; a load takes priority
  // over a drain so simultaneous transfers replace the word without a bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      out_err_d   = word_err;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // State and slice registers; reset discards any held word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      consec_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      consec_q    <= consec_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

`ifdef PARITY_CHECKER_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Lifetime error total: saturates at all-ones, ignores clr_fault.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_xfer && word_err && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Lifetime error total register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule
